ciphertext_tx_framer: RTL and testbench
=======================================

// Module: ciphertext_tx_framer
// PURPOSE
//  Downstream of xor_encrypt. Takes the completed parallel ciphertext and sends it
//  out serially as a framed packet: preamble, length, payload, checksum.
//  Gives the capture host a self-delimiting, integrity-checked stream on uo_out[1:0].
//  Reports status through oBusy, oDone and oOverrun.
// PARAMETERS
//  MSG_SIZE    64    payload width in bits; must be a multiple of 8 and <= 2040
//  PREAMBLE    8'hA5 sync byte sent first
//  GAP_CYCLES  4     idle cycles forced after each frame (oData_flag=0); min 1
// PORTS
//  clk         in   1                    system clock
//  rst_n       in   1                    asynchronous active-low reset
//  ena         in   1                    global enable; low = freeze all state
//  iData_in    in   MSG_SIZE             ciphertext from xor_encrypt
//  iCounter    in   $clog2(MSG_SIZE)+1   ciphertext bit counter; ==MSG_SIZE means complete
//  oData_out   out  1                    serial frame bit, MSB first
//  oData_flag  out  1                    high for every valid frame bit
//  oBusy       out  1                    high from capture through end of GAP
//  oDone       out  1                    1-cycle pulse on the last checksum bit
//  oOverrun    out  1                    sticky; a completion arrived while busy
// BEHAVIOUR
//  Clock and reset: single clock clk. rst_n is asynchronous, active-low.
//  Reset: all outputs 0, FSM in IDLE, shift register and counters cleared.
//   Reset mid-frame aborts the frame immediately; no partial checksum is sent.
//  Trigger: complete = (iCounter==MSG_SIZE). Registered copy complete_q.
//   Start = ena && complete && !complete_q (rising edge only). A level that stays
//   high does not retrigger.
//  FSM states: IDLE -> PRE -> LEN -> PAY -> CHK -> GAP -> IDLE.
//   IDLE: on start, latch iData_in and LRC, go to PRE. LRC = XOR of all payload bytes.
//   PRE:  8 bits of PREAMBLE.
//   LEN:  8 bits, value MSG_SIZE/8.
//   PAY:  MSG_SIZE bits, iData_in[MSG_SIZE-1] first.
//   CHK:  8 bits of LRC; oDone pulses with bit 0.
//   GAP:  GAP_CYCLES cycles with flag=0 and data=0, then IDLE.
//  Latency: start sampled at edge N; first preamble bit valid after edge N+1
//   (registered outputs). Frame length is MSG_SIZE+24 bits, flag high contiguously.
//  Bit counter: width $clog2(MSG_SIZE)+1. It reloads on every state change and
//   never wraps inside a field.
//  ena low: FSM, counters, shift register and outputs hold their values. Edge
//   detect is also frozen, so completion history is not lost or double-counted.
//  Simultaneous events:
//   - Start while not IDLE (including GAP): frame ignored, oOverrun<=1. The
//     in-flight frame is unaffected.
//   - Start on the same cycle GAP ends: counts as overrun.
//  oOverrun clears only on reset.
//  oData_out is 0 whenever oData_flag is 0.
//  Payload is latched, so iData_in may change freely after capture.
// STRUCTURE
//  Package ctx_frame_pkg:
//   - state enum (IDLE, PRE, LEN, PAY, CHK, GAP)
//   - FIELD_W=8
//   - function lrc8(payload), the byte-wise XOR
//   - localparam FRAME_BITS = MSG_SIZE+24
//  One sub-module is natural: ctx_shift_out. It is a loadable MSB-first PISO with
//   load/shift/hold controls and a down-counter, reused for each field.
//  The FSM and overrun logic stay in the top of this block.
// TESTING
//  1 Reset/idle: reset for 3 cycles, counter held at 0 -> all outputs 0; no flag
//    for 50 cycles.
//  2 Golden frame: iData_in=64'hDEADBEEF00000000, iCounter steps to 64 -> expected:
//    - flag high 88 cycles starting 1 cycle after the edge
//    - bits A5, 08, payload MSB first, LRC 8'h22
//    - oDone on the 88th bit; oBusy low 4 cycles later
//  3 Level hold: iCounter held at 64 for 500 cycles -> exactly one frame.
//    Dropping to 0 and back to 64 gives a second frame.
//  4 Overrun: second rising completion at frame bit 30, and another during GAP ->
//    first frame intact; oOverrun=1 and stays 1; no second frame.
//  5 ena stall: ena low for 10 cycles at payload bit 17 -> oData_out/flag frozen.
//    Resumed stream is identical to the golden frame apart from the stretch
//    (frame spans 98 cycles).
//  6 Reset mid-frame: rst_n low at CHK bit 3 -> outputs 0 asynchronously.
//    A new completion after release gives a full, correct frame.

Source files
------------

// File: rtl/ctx_frame_pkg.sv
// Shared types, field constants and the payload checksum helper for the ciphertext framer.
package ctx_frame_pkg;

   localparam int unsigned FIELD_W      = 8;
   localparam int unsigned MAX_MSG      = 2040;
   localparam int unsigned MSG_SIZE_DEF = 64;
   localparam int unsigned FRAME_BITS   = MSG_SIZE_DEF + 3 * FIELD_W;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      LEN,
      PAY,
      CHK,
      GAP
   } state_t;

   // Byte-wise XOR of a zero-extended payload; the padding bytes contribute nothing.
   function automatic logic [FIELD_W-1:0] lrc8(input logic [MAX_MSG-1:0] payload);
      logic [FIELD_W-1:0] acc;
      acc = '0;
      for (int unsigned i = 0; i < MAX_MSG / FIELD_W; i++) begin
         acc = acc ^ payload[i*FIELD_W +: FIELD_W];
      end
      return acc;
   endfunction

endpackage

// File: rtl/ctx_shift_out.sv
// Loadable MSB-first parallel-in serial-out register with a field down-counter.
module ctx_shift_out #(
   parameter int unsigned W  = 64,
   parameter int unsigned CW = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          shift,
   input  logic [W-1:0]  load_data,
   input  logic [CW-1:0] load_cnt,
   output logic          msb,
   output logic [CW-1:0] cnt
);

   logic [W-1:0] sr;

   // Load wins over shift; neither means hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= load_data;
         cnt <= load_cnt;
      end else if (shift) begin
         sr  <= sr << 1;
         cnt <= cnt - CW'(1);
      end
   end

   assign msb = sr[W-1];

endmodule

// File: rtl/ciphertext_tx_framer.sv
// Serialises a completed ciphertext as preamble, length, payload and LRC fields,
// with busy/done/overrun status and a forced idle gap after each frame.
module ciphertext_tx_framer
   import ctx_frame_pkg::*;
#(
   parameter int unsigned MSG_SIZE   = 64,
   parameter logic [7:0]  PREAMBLE   = 8'hA5,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic [MSG_SIZE-1:0]       iData_in,
   input  logic [$clog2(MSG_SIZE):0] iCounter,
   output logic                      oData_out,
   output logic                      oData_flag,
   output logic                      oBusy,
   output logic                      oDone,
   output logic                      oOverrun
);

   localparam int unsigned CNT_W = $clog2(MSG_SIZE) + 1;

   state_t               state, state_next;
   logic                 complete, complete_q, start_c;
   logic [MSG_SIZE-1:0]  payload_q;
   logic [FIELD_W-1:0]   lrc_q;
   logic                 sr_load, sr_shift, sr_msb;
   logic [MSG_SIZE-1:0]  sr_data;
   logic [CNT_W-1:0]     sr_cnt_load, sr_cnt;
   logic                 data_next, flag_next, done_next;

   // 8-bit fields sit in the top byte so the shared register shifts them MSB first.
   function automatic logic [MSG_SIZE-1:0] field8(input logic [FIELD_W-1:0] b);
      return MSG_SIZE'(b) << (MSG_SIZE - FIELD_W);
   endfunction

   assign complete = (iCounter == CNT_W'(MSG_SIZE));
   assign start_c  = ena && complete && !complete_q;

   ctx_shift_out #(
      .W  (MSG_SIZE),
      .CW (CNT_W)
   ) u_shift (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (sr_load && ena),
      .shift     (sr_shift && ena),
      .load_data (sr_data),
      .load_cnt  (sr_cnt_load),
      .msb       (sr_msb),
      .cnt       (sr_cnt)
   );

   // Next state, field sequencing and next output values.
   always_comb begin
      state_next  = state;
      sr_load     = 1'b0;
      sr_shift    = 1'b0;
      sr_data     = '0;
      sr_cnt_load = '0;
      data_next   = 1'b0;
      flag_next   = 1'b0;
      done_next   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_c) begin
               state_next  = PRE;
               sr_load     = 1'b1;
               sr_data     = field8(PREAMBLE);
               sr_cnt_load = CNT_W'(FIELD_W - 1);
            end
         end
         PRE, LEN, PAY, CHK: begin
            data_next = sr_msb;
            flag_next = 1'b1;
            sr_shift  = 1'b1;
            if (sr_cnt == '0) begin
               sr_load = 1'b1;
               if (state == PRE) begin
                  state_next  = LEN;
                  sr_data     = field8(FIELD_W'(MSG_SIZE / FIELD_W));
                  sr_cnt_load = CNT_W'(FIELD_W - 1);
               end else if (state == LEN) begin
                  state_next  = PAY;
                  sr_data     = payload_q;
                  sr_cnt_load = CNT_W'(MSG_SIZE - 1);
               end else if (state == PAY) begin
                  state_next  = CHK;
                  sr_data     = field8(lrc_q);
                  sr_cnt_load = CNT_W'(FIELD_W - 1);
               end else begin
                  state_next  = GAP;
                  sr_cnt_load = CNT_W'(GAP_CYCLES - 1);
                  done_next   = 1'b1;
               end
            end
         end
         GAP: begin
            sr_shift = 1'b1;
            if (sr_cnt == '0) begin
               state_next = IDLE;
               sr_load    = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, capture and registered outputs; everything freezes while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         complete_q <= 1'b0;
         payload_q  <= '0;
         lrc_q      <= '0;
         oData_out  <= 1'b0;
         oData_flag <= 1'b0;
         oBusy      <= 1'b0;
         oDone      <= 1'b0;
         oOverrun   <= 1'b0;
      end else if (ena) begin
         state      <= state_next;
         complete_q <= complete;
         oData_out  <= data_next;
         oData_flag <= flag_next;
         oDone      <= done_next;
         oBusy      <= (state_next != IDLE);
         if (start_c && state == IDLE) begin
            payload_q <= iData_in;
            lrc_q     <= lrc8(MAX_MSG'(iData_in));
         end
         if (start_c && state != IDLE) begin
            oOverrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ciphertext_tx_framer.sv
// Randomised and directed bench for ciphertext_tx_framer against a queue-based frame model.
module tb_ciphertext_tx_framer;

   localparam int unsigned MSG = 64;
   localparam int unsigned GAP = 4;
   localparam int unsigned FB  = ctx_frame_pkg::FRAME_BITS;

   typedef struct packed {
      logic data;
      logic flag;
      logic done;
      logic busy;
   } out_t;

   logic           clk      = 1'b0;
   logic           rst_n    = 1'b1;
   logic           ena      = 1'b1;
   logic [MSG-1:0] iData_in = '0;
   logic [6:0]     iCounter = '0;
   logic           oData_out, oData_flag, oBusy, oDone, oOverrun;

   int checks = 0;
   int errors = 0;

   ciphertext_tx_framer #(
      .MSG_SIZE   (MSG),
      .PREAMBLE   (8'hA5),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .iData_in   (iData_in),
      .iCounter   (iCounter),
      .oData_out  (oData_out),
      .oData_flag (oData_flag),
      .oBusy      (oBusy),
      .oDone      (oDone),
      .oOverrun   (oOverrun)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
      end
   endfunction

   function automatic logic [FB-1:0] frame_of(input logic [MSG-1:0] d);
      logic [7:0] l;
      l = '0;
      for (int b = 0; b < MSG / 8; b++) l = l ^ d[8*b +: 8];
      return {8'hA5, 8'(MSG / 8), d, l};
   endfunction

   // Model: a queue of per-cycle output tuples; busy covers the whole queued span.
   out_t exp_q[$];
   out_t exp_cur;
   logic m_cq, m_ovr, m_complete, m_start;

   task automatic push_frame(input logic [MSG-1:0] d);
      logic [FB-1:0] f;
      f = frame_of(d);
      exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
      for (int i = FB - 1; i >= 0; i--) exp_q.push_back('{f[i], 1'b1, (i == 0), 1'b1});
      for (int i = 0; i < GAP - 1; i++) exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_cur = '0;
         m_cq    = 1'b0;
         m_ovr   = 1'b0;
      end else if (ena) begin
         m_complete = (iCounter == 7'(MSG));
         m_start    = m_complete && !m_cq;
         m_cq       = m_complete;
         if (m_start) begin
            if (exp_cur.busy) m_ovr = 1'b1;
            else push_frame(iData_in);
         end
         if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
         else exp_cur = '0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("data",    oData_out,  exp_cur.data);
         chk("flag",    oData_flag, exp_cur.flag);
         chk("done",    oDone,      exp_cur.done);
         chk("busy",    oBusy,      exp_cur.busy);
         chk("overrun", oOverrun,   m_ovr);
      end
   end

   // Per-window observation statistics used by the directed checks.
   int w_first, w_nflag, w_done_idx, w_ndone, w_busy_low;
   logic [FB-1:0] w_bits;

   task automatic w_clear();
      w_first = -1; w_nflag = 0; w_done_idx = -1; w_ndone = 0; w_busy_low = -1; w_bits = '0;
   endtask

   task automatic w_sample(input int i);
      if (oData_flag) begin
         if (w_first < 0) w_first = i;
         w_nflag++;
         w_bits = {w_bits[FB-2:0], oData_out};
      end
      if (oDone) begin
         w_ndone++;
         w_done_idx = i;
      end
      if (!oBusy && i > 0 && w_busy_low < 0) w_busy_low = i;
   endtask

   task automatic arm(input logic [MSG-1:0] d);
      iCounter = '0;
      @(negedge clk);
      iData_in = d;
      iCounter = 7'(MSG);
   endtask

   initial begin
      logic [MSG-1:0] d;
      logic [FB-1:0]  golden;
      golden = {8'hA5, 8'h08, 64'hDEADBEEF00000000, 8'h22};

      // Reset and idle
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data", oData_out, 0);
      chk("rst_flag", oData_flag, 0);
      chk("rst_busy", oBusy, 0);
      chk("rst_done", oDone, 0);
      chk("rst_ovr",  oOverrun, 0);
      rst_n = 1'b1;
      w_clear();
      for (int i = 0; i < 50; i++) begin @(negedge clk); w_sample(i); end
      chk("idle_nflag", 32'(w_nflag), 0);
      chk("model_golden", frame_of(64'hDEADBEEF00000000), golden);

      // Golden frame, counter stepping up to completion
      iData_in = 64'hDEADBEEF00000000;
      iCounter = 7'd63;
      @(negedge clk);
      iCounter = 7'd64;
      w_clear();
      for (int i = 0; i < 120; i++) begin @(negedge clk); w_sample(i); end
      chk("gold_first",   32'(w_first), 1);
      chk("gold_nflag",   32'(w_nflag), 88);
      chk("gold_bits",    w_bits, golden);
      chk("gold_done",    32'(w_done_idx), 88);
      chk("gold_ndone",   32'(w_ndone), 1);
      chk("gold_busylow", 32'(w_busy_low), 92);

      // Level held high gives one frame; a fresh rising edge gives another
      arm({$urandom, $urandom});
      w_clear();
      for (int i = 0; i < 500; i++) begin @(negedge clk); w_sample(i); end
      chk("level_ndone", 32'(w_ndone), 1);
      chk("level_nflag", 32'(w_nflag), 88);
      arm({$urandom, $urandom});
      w_clear();
      for (int i = 0; i < 150; i++) begin @(negedge clk); w_sample(i); end
      chk("retrig_ndone", 32'(w_ndone), 1);

      // Overrun mid-frame and during the gap
      chk("ovr_clear", oOverrun, 0);
      arm({$urandom, $urandom});
      w_clear();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         w_sample(i);
         if (i == 40) chk("ovr_set", oOverrun, 1);
         if (i == 28 || i == 88) iCounter = '0;
         if (i == 29 || i == 89) iCounter = 7'(MSG);
      end
      chk("ovr_ndone", 32'(w_ndone), 1);
      chk("ovr_nflag", 32'(w_nflag), 88);
      chk("ovr_sticky", oOverrun, 1);

      // ena stall at payload bit 17
      d = {$urandom, $urandom};
      arm(d);
      w_clear();
      for (int i = 0; i < 130; i++) begin
         @(negedge clk);
         w_sample(i);
         if (i == 34) ena = 1'b0;
         if (i == 44) ena = 1'b1;
      end
      chk("stall_first", 32'(w_first), 1);
      chk("stall_nflag", 32'(w_nflag), 98);
      chk("stall_done",  32'(w_done_idx), 98);
      chk("stall_tail",  w_bits[53:0], frame_of(d) >> 0 & {{(FB-54){1'b0}}, {54{1'b1}}});

      // Reset during the checksum field
      arm({$urandom, $urandom});
      for (int i = 0; i < 86; i++) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_data", oData_out, 0);
      chk("arst_flag", oData_flag, 0);
      chk("arst_busy", oBusy, 0);
      chk("arst_done", oDone, 0);
      chk("arst_ovr",  oOverrun, 0);
      iCounter = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d = {$urandom, $urandom};
      arm(d);
      w_clear();
      for (int i = 0; i < 120; i++) begin @(negedge clk); w_sample(i); end
      chk("post_bits",  w_bits, frame_of(d));
      chk("post_nflag", 32'(w_nflag), 88);
      chk("post_done",  32'(w_done_idx), 88);
      chk("post_ovr",   oOverrun, 0);

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         ena      = ($urandom % 8) != 0;
         iData_in = {$urandom, $urandom};
         case ($urandom % 10)
            0, 1, 2, 3, 4, 5: ;
            6, 7, 8: iCounter = (iCounter == 7'(MSG)) ? 7'd0 : 7'(MSG);
            default: iCounter = 7'($urandom_range(0, 127));
         endcase
      end
      ena = 1'b1;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
